// File: rtl/ev_pkg.sv
// Shared definitions for the event-record packer: frame header byte,
// packer state encoding and the timestamp byte-count helper.
package ev_pkg;

    // First byte of every frame.
    localparam logic [7:0] FRAME_HDR = 8'hA5;

    // One state per frame field; IDLE is the only state that accepts a record.
    typedef enum logic [2:0] {
        IDLE,
        HDR,
        SEQ,
        ID,
        START,
        END,
        DELTA,
        CSUM
    } pack_state_e;

    // Number of bytes needed to carry a ts_w-bit timestamp field.
    function automatic int ts_bytes(input int ts_w);
        return (ts_w + 7) / 8;
    endfunction

endpackage

// File: rtl/ev_rec_packer.sv
// Event-record packer: accepts one timing record (id, start, end, delta)
// and serialises it as a byte frame
//   A5, seq, id, start[TB], end[TB], delta[TB], xor-checksum
// with multi-byte fields sent MSB byte first.
module ev_rec_packer
    import ev_pkg::*;
#(
    parameter int ID_W = 3,
    parameter int TS_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [ID_W-1:0] in_id,
    input  logic [TS_W-1:0] in_start_ts,
    input  logic [TS_W-1:0] in_end_ts,
    input  logic [TS_W-1:0] in_delta,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [7:0]      m_data,
    output logic            m_last
);

    localparam int TB    = ts_bytes(TS_W);
    localparam int EXT_W = TB * 8;
    localparam int IDX_W = (TB > 1) ? $clog2(TB) : 1;
    localparam int NSLOT = 1 << IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TB - 1);

    pack_state_e      state_reg, state_next;
    logic [IDX_W-1:0] byte_idx_reg, byte_idx_next;
    logic [7:0]       seq_reg, seq_next;
    logic [7:0]       csum_reg, csum_next;
    logic             in_ready_reg;

    logic [ID_W-1:0]  id_reg;
    logic [TS_W-1:0]  start_reg;
    logic [TS_W-1:0]  end_reg;
    logic [TS_W-1:0]  delta_reg;

    logic [EXT_W-1:0] start_ext;
    logic [EXT_W-1:0] end_ext;
    logic [EXT_W-1:0] delta_ext;

    logic [7:0]       start_byte [NSLOT];
    logic [7:0]       end_byte   [NSLOT];
    logic [7:0]       delta_byte [NSLOT];

    logic             in_fire;
    logic             m_fire;
    logic [7:0]       cur_byte;

    assign in_ready = in_ready_reg;
    assign in_fire  = in_valid & in_ready_reg;
    assign m_valid  = (state_reg != IDLE);
    assign m_fire   = m_valid & m_ready;
    assign m_last   = (state_reg == CSUM);
    assign m_data   = cur_byte;

    // Zero-extend captured timestamps to a whole number of bytes.
    assign start_ext = EXT_W'(start_reg);
    assign end_ext   = EXT_W'(end_reg);
    assign delta_ext = EXT_W'(delta_reg);

    // Byte slot k holds the k-th transmitted byte (MSB first); slots past TB
    // only exist to round the index range up to a power of two.
    for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
        if (gi < TB) begin : g_used
            assign start_byte[gi] = start_ext[(TB-1-gi)*8 +: 8];
            assign end_byte[gi]   = end_ext[(TB-1-gi)*8 +: 8];
            assign delta_byte[gi] = delta_ext[(TB-1-gi)*8 +: 8];
        end else begin : g_pad
            assign start_byte[gi] = 8'h00;
            assign end_byte[gi]   = 8'h00;
            assign delta_byte[gi] = 8'h00;
        end
    end

    // State, byte index, sequence and checksum registers; in_ready is
    // registered so it never follows m_ready combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            byte_idx_reg <= '0;
            seq_reg      <= 8'h00;
            csum_reg     <= 8'h00;
            in_ready_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            byte_idx_reg <= byte_idx_next;
            seq_reg      <= seq_next;
            csum_reg     <= csum_next;
            in_ready_reg <= (state_next == IDLE);
        end
    end

    // Capture the offered record on the input handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_reg    <= '0;
            start_reg <= '0;
            end_reg   <= '0;
            delta_reg <= '0;
        end else if (in_fire) begin
            id_reg    <= in_id;
            start_reg <= in_start_ts;
            end_reg   <= in_end_ts;
            delta_reg <= in_delta;
        end
    end

    // Next-state logic and the byte presented in each state.
    always_comb begin
        state_next    = state_reg;
        byte_idx_next = byte_idx_reg;
        seq_next      = seq_reg;
        csum_next     = csum_reg;
        cur_byte      = 8'h00;

        case (state_reg)
            IDLE: begin
                if (in_fire) begin
                    state_next    = HDR;
                    byte_idx_next = '0;
                    csum_next     = 8'h00;
                end
            end
            HDR: begin
                cur_byte = FRAME_HDR;
                if (m_fire) state_next = SEQ;
            end
            SEQ: begin
                cur_byte = seq_reg;
                if (m_fire) state_next = ID;
            end
            ID: begin
                cur_byte = 8'(id_reg);
                if (m_fire) state_next = START;
            end
            START: begin
                cur_byte = start_byte[byte_idx_reg];
                if (m_fire) begin
                    if (byte_idx_reg == LAST_IDX) begin
                        byte_idx_next = '0;
                        state_next    = END;
                    end else begin
                        byte_idx_next = byte_idx_reg + 1'b1;
                    end
                end
            end
            END: begin
                cur_byte = end_byte[byte_idx_reg];
                if (m_fire) begin
                    if (byte_idx_reg == LAST_IDX) begin
                        byte_idx_next = '0;
                        state_next    = DELTA;
                    end else begin
                        byte_idx_next = byte_idx_reg + 1'b1;
                    end
                end
            end
            DELTA: begin
                cur_byte = delta_byte[byte_idx_reg];
                if (m_fire) begin
                    if (byte_idx_reg == LAST_IDX) begin
                        byte_idx_next = '0;
                        state_next    = CSUM;
                    end else begin
                        byte_idx_next = byte_idx_reg + 1'b1;
                    end
                end
            end
            CSUM: begin
                cur_byte = csum_reg;
                if (m_fire) begin
                    state_next = IDLE;
                    seq_next   = seq_reg + 8'h01;
                    csum_next  = 8'h00;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Every byte before the checksum folds into the running XOR.
        if (m_fire && (state_reg != CSUM)) begin
            csum_next = csum_reg ^ cur_byte;
        end
    end

endmodule

// File: tb/tb_ev_rec_packer.sv
// Self-checking bench for ev_rec_packer: a frame-level model predicts the
// byte stream of every accepted record; directed cases pin known frames.
`timescale 1ns/1ps
module tb_ev_rec_packer;

    typedef logic [7:0] byte_q_t [$];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance (TS_W=8).
    logic       a_in_valid = 1'b0;
    logic       a_in_ready;
    logic [2:0] a_in_id = '0;
    logic [7:0] a_in_start_ts = '0;
    logic [7:0] a_in_end_ts = '0;
    logic [7:0] a_in_delta = '0;
    logic       a_m_valid;
    logic       a_m_ready = 1'b1;
    logic [7:0] a_m_data;
    logic       a_m_last;

    // Wide-timestamp instance (TS_W=12).
    logic        b_in_valid = 1'b0;
    logic        b_in_ready;
    logic [2:0]  b_in_id = '0;
    logic [11:0] b_in_start_ts = '0;
    logic [11:0] b_in_end_ts = '0;
    logic [11:0] b_in_delta = '0;
    logic        b_m_valid;
    logic        b_m_ready = 1'b1;
    logic [7:0]  b_m_data;
    logic        b_m_last;

    ev_rec_packer u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_id(a_in_id),
        .in_start_ts(a_in_start_ts), .in_end_ts(a_in_end_ts), .in_delta(a_in_delta),
        .m_valid(a_m_valid), .m_ready(a_m_ready), .m_data(a_m_data), .m_last(a_m_last)
    );

    ev_rec_packer #(.ID_W(3), .TS_W(12)) u_dut_w (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_id(b_in_id),
        .in_start_ts(b_in_start_ts), .in_end_ts(b_in_end_ts), .in_delta(b_in_delta),
        .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data), .m_last(b_m_last)
    );

    int checks = 0;
    int failures = 0;

    byte_q_t exp_q;
    byte_q_t cap_q;
    logic    last_q [$];
    logic [7:0] seq_m = 8'h00;
    logic    armed = 1'b0;
    logic    rand_rdy = 1'b0;
    logic    b2b = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Frame model: header, seq, id, three big-endian fields, XOR of all.
    function automatic byte_q_t build_frame(input int tb, input logic [7:0] id8,
                                            input logic [31:0] s, input logic [31:0] e,
                                            input logic [31:0] d, input logic [7:0] seq);
        byte_q_t f;
        logic [31:0] flds [3];
        logic [7:0] x;
        flds[0] = s; flds[1] = e; flds[2] = d;
        f.push_back(8'hA5);
        f.push_back(seq);
        f.push_back(id8);
        for (int n = 0; n < 3; n++)
            for (int k = tb - 1; k >= 0; k--)
                f.push_back(8'(flds[n] >> (8 * k)));
        x = 8'h00;
        foreach (f[i]) x = x ^ f[i];
        f.push_back(x);
        return f;
    endfunction

    // in_ready may only rise on a clock edge seen with reset released.
    initial forever begin
        @(posedge clk or negedge rst_n);
        armed = rst_n;
    end

    // Compare process for the default instance, sampled on the falling edge.
    initial begin : compare
        logic       prev_stall;
        logic [7:0] prev_data;
        logic       prev_valid;
        logic       seen_end;
        int         idle_run;
        prev_stall = 0; prev_data = 0; prev_valid = 0; seen_end = 0; idle_run = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_m_valid", 32'(a_m_valid), 0);
                chk("rst_m_last", 32'(a_m_last), 0);
                chk("rst_m_data", 32'(a_m_data), 0);
                chk("rst_in_ready", 32'(a_in_ready), 0);
                exp_q.delete();
                seq_m = 8'h00;
                prev_stall = 0; prev_valid = 0; seen_end = 0; idle_run = 0;
            end else begin
                chk("in_ready", 32'(a_in_ready), 32'(armed && exp_q.size() == 0));
                chk("m_valid", 32'(a_m_valid), 32'(exp_q.size() != 0));
                if (prev_stall) chk("hold_data", 32'(a_m_data), 32'(prev_data));
                if (a_m_valid && exp_q.size() != 0) begin
                    chk("m_data", 32'(a_m_data), 32'(exp_q[0]));
                    chk("m_last", 32'(a_m_last), 32'(exp_q.size() == 1));
                    if (!prev_valid && seen_end) begin
                        if (b2b) chk("gap_exact", 32'(idle_run), 1);
                        else     chk("gap_min", 32'(idle_run >= 1), 1);
                    end
                end else begin
                    chk("m_last_idle", 32'(a_m_last), 0);
                end
                prev_stall = a_m_valid && !a_m_ready;
                prev_data  = a_m_data;
                prev_valid = a_m_valid;
                if (!a_m_valid) idle_run++;
                if (a_m_valid && a_m_ready && exp_q.size() != 0) begin
                    cap_q.push_back(a_m_data);
                    last_q.push_back(a_m_last);
                    void'(exp_q.pop_front());
                    if (exp_q.size() == 0) begin
                        seq_m++;
                        seen_end = 1;
                        idle_run = 0;
                    end
                end
                if (a_in_valid && a_in_ready)
                    exp_q = build_frame(1, 8'(a_in_id), 32'(a_in_start_ts),
                                        32'(a_in_end_ts), 32'(a_in_delta), seq_m);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_rdy) a_m_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input logic [2:0] id, input logic [7:0] s,
                        input logic [7:0] e, input logic [7:0] d);
        int n;
        a_in_valid = 1'b1;
        a_in_id = id; a_in_start_ts = s; a_in_end_ts = e; a_in_delta = d;
        n = 0;
        while (!a_in_ready && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) chk("send_timeout", 1, 0);
        step();
        a_in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((a_m_valid || exp_q.size() != 0) && n < 500) begin
            step();
            n++;
        end
        if (n >= 500) chk("drain_timeout", 1, 0);
    endtask

    task automatic rst_pulse();
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("in_ready_before_edge", 32'(a_in_ready), 0);
        step();
        chk("in_ready_first_edge", 32'(a_in_ready), 1);
    endtask

    task automatic chk_frame(input string name, input byte_q_t want);
        chk({name, "_len"}, 32'(cap_q.size()), 32'(want.size()));
        for (int i = 0; i < want.size() && i < cap_q.size(); i++) begin
            chk({name, "_byte"}, 32'(cap_q[i]), 32'(want[i]));
            chk({name, "_last"}, 32'(last_q[i]), 32'(i == want.size() - 1));
        end
    endtask

    initial begin : stim
        byte_q_t lit;
        byte_q_t mdl;
        byte_q_t wcap;
        logic    wlast [$];
        int      n;

        // Reset and release.
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("in_ready_before_edge", 32'(a_in_ready), 0);
        step();
        chk("in_ready_first_edge", 32'(a_in_ready), 1);

        // Pin the model against a hand-computed frame.
        lit = '{8'hA5, 8'h00, 8'h03, 8'h0A, 8'h11, 8'h07, 8'hBA};
        mdl = build_frame(1, 8'h03, 32'd10, 32'd17, 32'd7, 8'h00);
        for (int i = 0; i < 7; i++) chk("model_basic", 32'(mdl[i]), 32'(lit[i]));

        // Basic frame.
        cap_q.delete(); last_q.delete();
        send(3'd3, 8'd10, 8'd17, 8'd7);
        wait_idle();
        chk_frame("basic", lit);

        // Wide timestamps on the TS_W=12 instance.
        lit = '{8'hA5, 8'h00, 8'h01, 8'h0A, 8'hBC, 8'h0F, 8'hFF, 8'h05, 8'h43, 8'hA4};
        mdl = build_frame(2, 8'h01, 32'hABC, 32'hFFF, 32'h543, 8'h00);
        for (int i = 0; i < 10; i++) chk("model_wide", 32'(mdl[i]), 32'(lit[i]));
        b_in_valid = 1'b1;
        b_in_id = 3'd1; b_in_start_ts = 12'hABC; b_in_end_ts = 12'hFFF; b_in_delta = 12'h543;
        n = 0;
        while (!b_in_ready && n < 50) begin step(); n++; end
        step();
        b_in_valid = 1'b0;
        n = 0;
        while (n < 40) begin
            if (b_m_valid && b_m_ready) begin
                wcap.push_back(b_m_data);
                wlast.push_back(b_m_last);
                if (b_m_last) n = 40;
            end
            step();
            n++;
        end
        chk("wide_len", 32'(wcap.size()), 10);
        for (int i = 0; i < 10 && i < wcap.size(); i++) begin
            chk("wide_byte", 32'(wcap[i]), 32'(lit[i]));
            chk("wide_last", 32'(wlast[i]), 32'(i == 9));
        end

        // Backpressure on the start_ts byte, starting from a fresh seq.
        rst_pulse();
        lit = '{8'hA5, 8'h00, 8'h03, 8'h0A, 8'h11, 8'h07, 8'hBA};
        cap_q.delete(); last_q.delete();
        a_m_ready = 1'b1;
        send(3'd3, 8'd10, 8'd17, 8'd7);
        n = 0;
        while (cap_q.size() < 3 && n < 50) begin step(); n++; end
        a_m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_data", 32'(a_m_data), 32'h0A);
            chk("bp_valid", 32'(a_m_valid), 1);
            chk("bp_in_ready", 32'(a_in_ready), 0);
            step();
        end
        chk("bp_data_end", 32'(a_m_data), 32'h0A);
        a_m_ready = 1'b1;
        wait_idle();
        chk_frame("bp", lit);

        // Delta passes through even when end < start.
        cap_q.delete(); last_q.delete();
        send(3'd2, 8'd250, 8'd4, 8'd10);
        wait_idle();
        chk("delta_len", 32'(cap_q.size()), 7);
        if (cap_q.size() == 7) chk("delta_byte", 32'(cap_q[5]), 32'h0A);

        // Reset during the id byte aborts the frame.
        send(3'd5, 8'd1, 8'd2, 8'd3);
        n = 0;
        while (cap_q.size() < 9 && n < 50) begin step(); n++; end
        chk("pre_rst_id_valid", 32'(a_m_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_m_valid", 32'(a_m_valid), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        cap_q.delete(); last_q.delete();
        send(3'd6, 8'd20, 8'd30, 8'd10);
        wait_idle();
        chk("after_rst_hdr", 32'(cap_q.size() > 1 ? cap_q[0] : 8'h00), 32'hA5);
        chk("after_rst_seq", 32'(cap_q.size() > 1 ? cap_q[1] : 8'hFF), 32'h00);

        // Randomized records with random backpressure and gaps.
        rand_rdy = 1'b1;
        for (int r = 0; r < 40; r++) begin
            send(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
                 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            n = $urandom_range(0, 3);
            for (int k = 0; k < n; k++) step();
        end
        wait_idle();
        rand_rdy = 1'b0;
        a_m_ready = 1'b1;

        // Sequence wrap with back-to-back records.
        rst_pulse();
        cap_q.delete(); last_q.delete();
        b2b = 1'b1;
        for (int r = 0; r < 257; r++)
            send(3'(r), 8'(r), 8'(r + 7), 8'd7);
        wait_idle();
        b2b = 1'b0;
        chk("wrap_len", 32'(cap_q.size()), 257 * 7);
        if (cap_q.size() == 257 * 7)
            for (int r = 0; r < 257; r++)
                chk("wrap_seq", 32'(cap_q[r * 7 + 1]), 32'(r & 8'hFF));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
